// File: rtl/scan_unload_tx.sv
// Framed parallel-to-serial unload transmitter: start bit, WIDTH data bits LSB first,
// optional even parity, stop bit; each bit held CLKS_PER_BIT clocks. Line idles high.
module scan_unload_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             serial_out,
   output logic             busy,
   output logic             frame_done,
   output logic [2:0]       dbg_state
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cyc;
   logic [BW-1:0]    r_bit;
   logic [WIDTH-1:0] r_shift;
   logic             r_par;
   logic             r_serial;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_bit_end;
   logic [WIDTH-1:0] w_shift_next;

   // Handshake: a word transfers on a rising edge where data_valid and data_ready
   // are both high; data_ready is high only in IDLE, so the producer must hold
   // data_valid and data_in stable until it sees that edge.
   assign w_accept     = data_valid & r_ready;
   assign w_bit_end    = (r_cyc == LAST_CYC);
   assign w_shift_next = r_shift >> 1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cyc    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_serial <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != S_IDLE) begin
            r_cyc <= w_bit_end ? '0 : r_cyc + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift  <= data_in;
                  r_par    <= ^data_in;
                  r_cyc    <= '0;
                  r_state  <= S_START;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b1;
                  r_ready  <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state  <= S_DATA;
                  r_serial <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit == LAST_BIT) begin
                     r_bit <= '0;
                     if (PARITY_EN != 0) begin
                        r_state  <= S_PARITY;
                        r_serial <= r_par;
                     end else begin
                        r_state  <= S_STOP;
                        r_serial <= 1'b1;
                     end
                  end else begin
                     // Next data bit comes from the shifted word, never from data_in.
                     r_bit    <= r_bit + 1'b1;
                     r_shift  <= w_shift_next;
                     r_serial <= w_shift_next[0];
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state  <= S_STOP;
                  r_serial <= 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_state  <= S_IDLE;
                  r_serial <= 1'b1;
                  r_busy   <= 1'b0;
                  r_ready  <= 1'b1;
                  r_done   <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_serial <= 1'b1;
               r_busy   <= 1'b0;
               r_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign data_ready = r_ready;
   assign serial_out = r_serial;
   assign busy       = r_busy;
   assign frame_done = r_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_scan_unload_tx.sv
// Bench for scan_unload_tx: default instance (8 bits, 4 clk/bit, parity) and a
// 5-bit, 1 clk/bit, no-parity instance, checked against a frame-queue model.
module tb_scan_unload_tx;

   localparam int WA = 8, CA = 4, PA = 1;
   localparam int WB = 5, CB = 1, PB = 0;
   localparam int NA = (2 + WA + PA) * CA;
   localparam int NB = (2 + WB + PB) * CB;

   logic clock = 1'b0;
   logic reset_n;
   logic          va, vb;
   logic [WA-1:0] da;
   logic [WB-1:0] db;
   logic ready_a, serial_a, busy_a, done_a;
   logic ready_b, serial_b, busy_b, done_b;
   logic [2:0] state_a, state_b;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   always #5 clock = ~clock;

   scan_unload_tx #(.WIDTH(WA), .CLKS_PER_BIT(CA), .PARITY_EN(PA)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .data_in(da), .data_valid(va),
      .data_ready(ready_a), .serial_out(serial_a), .busy(busy_a),
      .frame_done(done_a), .dbg_state(state_a)
   );

   scan_unload_tx #(.WIDTH(WB), .CLKS_PER_BIT(CB), .PARITY_EN(PB)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .data_in(db), .data_valid(vb),
      .data_ready(ready_b), .serial_out(serial_b), .busy(busy_b),
      .frame_done(done_b), .dbg_state(state_b)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Line level of bit b of a frame: 0 start, data LSB first, even parity, 1 stop.
   function automatic logic frame_bit(input logic [15:0] w, input int b, input int wd, input int pe);
      logic [15:0] m;
      m = w & 16'((1 << wd) - 1);
      if (b == 0) return 1'b0;
      if (b <= wd) return w[b-1];
      if (pe != 0 && b == wd + 1) return ^m;
      return 1'b1;
   endfunction

   function automatic logic [63:0] expand(input logic [15:0] fr, input int nbits, input int c);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < nbits * c; k++) v[k] = fr[k / c];
      return v;
   endfunction

   // Model: a queue holding the expected line level for every remaining frame cycle.
   logic exp_qa[$];
   logic exp_qb[$];
   logic m_done_a = 1'b0, m_done_b = 1'b0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exp_qa.delete(); exp_qb.delete();
         m_done_a = 1'b0; m_done_b = 1'b0;
      end else begin
         m_done_a = 1'b0;
         m_done_b = 1'b0;
         if (exp_qa.size() != 0) begin
            void'(exp_qa.pop_front());
            if (exp_qa.size() == 0) m_done_a = 1'b1;
         end else if (va) begin
            for (int b = 0; b < 2 + WA + PA; b++)
               for (int c = 0; c < CA; c++) exp_qa.push_back(frame_bit(16'(da), b, WA, PA));
         end
         if (exp_qb.size() != 0) begin
            void'(exp_qb.pop_front());
            if (exp_qb.size() == 0) m_done_b = 1'b1;
         end else if (vb) begin
            for (int b = 0; b < 2 + WB + PB; b++)
               for (int c = 0; c < CB; c++) exp_qb.push_back(frame_bit(16'(db), b, WB, PB));
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("a_serial", 64'(serial_a), 64'(exp_qa.size() != 0 ? exp_qa[0] : 1'b1));
         check("a_busy",   64'(busy_a),   64'(exp_qa.size() != 0));
         check("a_ready",  64'(ready_a),  64'(exp_qa.size() == 0));
         check("a_done",   64'(done_a),   64'(m_done_a));
         check("b_serial", 64'(serial_b), 64'(exp_qb.size() != 0 ? exp_qb[0] : 1'b1));
         check("b_busy",   64'(busy_b),   64'(exp_qb.size() != 0));
         check("b_ready",  64'(ready_b),  64'(exp_qb.size() == 0));
         check("b_done",   64'(done_b),   64'(m_done_b));
      end
   end

   // Recorder of the line while busy, plus frame_done pulse counts.
   logic cap_qa[$];
   logic cap_qb[$];
   int done_cnt_a = 0, done_cnt_b = 0;

   always @(negedge clock) begin
      if (chk_en) begin
         if (busy_a) cap_qa.push_back(serial_a);
         if (busy_b) cap_qb.push_back(serial_b);
         if (done_a) done_cnt_a++;
         if (done_b) done_cnt_b++;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic clear_caps();
      cap_qa.delete(); cap_qb.delete();
      done_cnt_a = 0; done_cnt_b = 0;
   endtask

   task automatic send_a(input logic [WA-1:0] w);
      int t = 0;
      while (!ready_a && t < 200) begin tick(); t++; end
      check("a_ready_wait", 64'(ready_a), 64'd1);
      va = 1'b1; da = w;
      @(posedge clock); #1;
      va = 1'b0;
   endtask

   task automatic wait_idle_a();
      int t = 0;
      do begin tick(); t++; end while (busy_a && t < 300);
      check("a_idle_wait", 64'(busy_a), 64'd0);
   endtask

   task automatic check_cap_a(input string nm, input logic [15:0] fr, input int off);
      logic [63:0] act;
      act = '0;
      for (int k = 0; k < NA; k++) act[k] = (off + k < cap_qa.size()) ? cap_qa[off + k] : 1'bx;
      check(nm, act, expand(fr, 2 + WA + PA, CA));
   endtask

   initial begin
      int ones;
      int gap;
      int t;
      logic [63:0] act;
      reset_n = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
      #1 reset_n = 1'b0;
      #1 chk_en = 1'b1;
      tick();
      check("reset_outputs_a", 64'({serial_a, ready_a, busy_a, done_a, state_a}), 64'b1100_000);
      check("reset_outputs_b", 64'({serial_b, ready_b, busy_b, done_b}), 64'b1100);
      reset_n = 1'b1;
      repeat (2) tick();

      // 0xA5: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1
      clear_caps();
      send_a(8'hA5);
      wait_idle_a();
      check_cap_a("a5_frame", 16'b1_0_10100101_0, 0);
      check("a5_busy_cycles", 64'(cap_qa.size()), 64'd44);
      check("a5_done_pulses", 64'(done_cnt_a), 64'd1);
      check("a5_ready_back", 64'(ready_a), 64'd1);

      // 0x07: parity bit 1, four ones across data+parity
      clear_caps();
      send_a(8'h07);
      wait_idle_a();
      check_cap_a("x07_frame", 16'b1_1_00000111_0, 0);
      ones = 0;
      for (int b = 1; b <= 9; b++) if (cap_qa.size() > b * 4 + 2) ones += int'(cap_qa[b * 4 + 2]);
      check("x07_ones", 64'(ones), 64'd4);

      // Back-to-back with data_valid held: 0x3C then 0xFF
      clear_caps();
      tick();
      va = 1'b1; da = 8'h3C;
      @(posedge clock); #1;
      da = 8'hFF;
      t = 0;
      while (busy_a && t < 200) begin tick(); t++; end
      gap = 0;
      while (!busy_a && gap < 10) begin gap++; tick(); end
      va = 1'b0;
      check("b2b_gap", 64'(gap), 64'd1);
      wait_idle_a();
      check_cap_a("b2b_frame1", 16'b1_0_00111100_0, 0);
      check_cap_a("b2b_frame2", 16'b1_0_11111111_0, NA);
      check("b2b_done_pulses", 64'(done_cnt_a), 64'd2);

      // Hold-off: data_in toggled and data_valid pulsed while busy
      clear_caps();
      send_a(8'h81);
      da = 8'h00;
      repeat (4) tick();
      for (int p = 0; p < 3; p++) begin
         va = 1'b1; tick(); va = 1'b0; repeat (5) tick();
      end
      wait_idle_a();
      repeat (5) tick();
      check_cap_a("holdoff_frame", 16'b1_0_10000001_0, 0);
      check("holdoff_busy_cycles", 64'(cap_qa.size()), 64'd44);
      check("holdoff_done_pulses", 64'(done_cnt_a), 64'd1);

      // Reset mid-DATA: outputs go idle immediately, no frame after release
      send_a(8'h55);
      repeat (20) tick();
      check("pre_reset_busy", 64'(busy_a), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midframe_reset", 64'({serial_a, ready_a, busy_a, done_a}), 64'b1100);
      tick();
      clear_caps();
      reset_n = 1'b1;
      repeat (10) tick();
      check("post_reset_no_frame", 64'(cap_qa.size()), 64'd0);
      check("post_reset_no_done", 64'(done_cnt_a), 64'd0);

      // Small instance: 0x15 -> 0,1,0,1,0,1,1
      clear_caps();
      tick();
      check("b_ready_pre", 64'(ready_b), 64'd1);
      vb = 1'b1; db = 5'h15;
      @(posedge clock); #1;
      vb = 1'b0;
      t = 0;
      do begin tick(); t++; end while (busy_b && t < 50);
      check("b_idle_wait", 64'(busy_b), 64'd0);
      act = '0;
      for (int k = 0; k < NB; k++) act[k] = (k < cap_qb.size()) ? cap_qb[k] : 1'bx;
      check("b15_frame", act, 64'b1101010);
      check("b15_busy_cycles", 64'(cap_qb.size()), 64'd7);
      check("b15_done_pulses", 64'(done_cnt_b), 64'd1);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scan_unload_tx.md
Name: scan_unload_tx

Overview:
- Parallel-to-serial transmitter that reads out a captured flop-state word and drives it onto a single-wire serial line.
- It is the unload/read side for the rising-edge-capture dff cells: a test controller hands it a captured word through a valid/ready handshake.
- It emits a framed serial stream: start bit, data bits LSB first, optional even parity, then stop bit.
- Sits between the capture register bank and the off-chip tester pin.

Parameters:
- WIDTH, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
- PARITY_EN, 1, 1 = insert even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on an accepting edge.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  block can accept a word; high only in IDLE.
- serial_out  output  1  serial line; idles high; registered.
- busy  output  1  high from START through STOP inclusive.
- frame_done  output  1  one-cycle pulse after the final STOP cycle.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-frame):
  - State = IDLE.
  - serial_out=1, data_ready=1, busy=0, frame_done=0.
  - Bit counter, cycle counter and shift register = 0.
  - Release is synchronous to the next rising edge; IDLE is the first state after release.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Accept: on a rising edge where data_valid=1 and data_ready=1 (IDLE only):
  - data_in is latched into the shift register.
  - Even parity = XOR of data_in is latched.
  - State becomes START, serial_out=0, busy=1, data_ready=0 after that same edge.
- Each of START, every DATA bit, PARITY and STOP holds serial_out for exactly CLKS_PER_BIT cycles.
  - A cycle counter counts 0..CLKS_PER_BIT-1; it is $clog2-sized, min 1 bit.
- DATA: bit i (i = 0..WIDTH-1, LSB first) is driven during the i-th bit period. The bit index counter wraps back to 0 on leaving DATA.
- PARITY: serial_out = latched XOR; total ones including the parity bit is even.
- STOP: serial_out=1.
- On the edge ending the last STOP cycle:
  - State becomes IDLE, busy=0, data_ready=1.
  - frame_done=1 for exactly that one following cycle.
- Frame length: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles, counted from the accept edge to the edge returning to IDLE.
- Back-to-back words:
  - A word can be accepted on the first edge after the return to IDLE, so serial_out=1 for at least one cycle between frames.
  - frame_done and a new accept may coincide on that edge.
- Inputs while busy: data_valid and data_in changes are ignored; no queueing; the producer holds data_valid until it sees data_ready.
- data_valid=1 held continuously: words are consumed one per frame, each at its own IDLE-cycle handshake.
- CLKS_PER_BIT=1: one cycle per bit; no special case.
- No X propagation: serial_out is driven from registers only, never combinationally from data_in.

Test Plan:
- Reset: assert reset_n=0 mid-DATA of a frame -> same cycle serial_out=1, busy=0, data_ready=1, frame_done=0; after release, IDLE persists with no spurious frame.
- Single frame, defaults (WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1), data_in=0xA5 -> serial_out sequence, each bit 4 cycles:
  - 0 (start), then 1,0,1,0,0,1,0,1 (data), then 0 (parity), then 1 (stop).
  - busy high 44 cycles; frame_done pulses once at cycle 44; data_ready returns high.
- Odd parity data: data_in=0x07 -> parity bit = 1; serial-side checker counts 4 ones across data+parity.
- Back-to-back: data_valid held high with 0x3C then 0xFF -> two frames separated by exactly one idle-high cycle; the second frame's bits are 1 x8 and parity 0.
- Handshake hold-off: toggle data_in to 0x00 during a 0x81 frame -> transmitted bits still 1,0,0,0,0,0,0,1; data_valid pulses while busy are not accepted.
- Parameter sweep: WIDTH=5, CLKS_PER_BIT=1, PARITY_EN=0, data_in=0x15 -> 7-cycle frame: 0,1,0,1,0,1,1; no parity bit.
